// File: rtl/vector_pkg.sv
// ----------------------------------------------------------------------------
// vector_pkg
// Shared definitions for the vector capture block: capture FSM state
// encoding, default buffer geometry, the "length 0" word count, and the small
// helpers used by the trigger and length logic.
// No ports (package).
// ----------------------------------------------------------------------------
package vector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  localparam int unsigned FIFO_DEPTH_DEF = 1024;
  localparam int unsigned BLOCK_SIZE_DEF = 256;

  // Word counter / length width: must hold 65536.
  localparam int unsigned LEN_W = 17;
  localparam logic [LEN_W-1:0] LEN_ZERO_WORDS = 17'd65536;

  // Effective number of words for a programmed capture_length.
  function automatic logic [LEN_W-1:0] capture_words(input logic [15:0] len);
    logic [LEN_W-1:0] words;
    if (len == 16'd0) begin
      words = LEN_ZERO_WORDS;
    end else begin
      words = {1'b0, len};
    end
    return words;
  endfunction

  // Masked trigger compare; a zero mask always matches.
  function automatic logic trig_match(input logic [31:0] sample,
                                      input logic [31:0] mask,
                                      input logic [31:0] value);
    return ((sample & mask) == (value & mask));
  endfunction

endpackage

// File: rtl/vector_sync_fifo.sv
// ----------------------------------------------------------------------------
// vector_sync_fifo
// Single-clock FIFO with registered read data, intended to map onto block RAM.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wr_en, wr_data    write request; dropped when full unless a read in the
//                     same cycle frees a slot
//   rd_en             pop request; when empty, rd_data is driven to zero
//   rd_data           registered popped word, held until the next pop
//   full, empty       status decoded from count
//   count             words buffered, 0..DEPTH
// ----------------------------------------------------------------------------
module vector_sync_fifo #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             do_rd, do_wr;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == {CW{1'b0}});
  assign count   = count_q;
  assign rd_data = rd_data_q;

  // Next-state for pointers, occupancy and read data.
  always_comb begin
    do_rd     = rd_en & ~empty;
    // A same-cycle pop frees the slot the write needs when full.
    do_wr     = wr_en & (~full | do_rd);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;

    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (do_rd) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = mem[rd_ptr_q];
    end else if (rd_en) begin
      rd_data_d = {WIDTH{1'b0}};
    end else begin
      rd_data_d = rd_data_q;
    end

    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; no reset so it infers as RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Pointer, occupancy and read-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      rd_data_q <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/vector_capture_32in.sv
// ----------------------------------------------------------------------------
// vector_capture_32in
// Triggered capture of a 32-bit asynchronous vector into a FIFO that is
// drained by a PC pipe-out interface.
// Ports:
//   vectorclk, vectorreset       clock, asynchronous active-high reset
//   vectorinput[31:0]            asynchronous inputs (two-flop synchronized)
//   capture_arm                  pulse; arms a capture from IDLE or DONE
//   trig_mask/trig_value[31:0]   masked trigger compare, latched when arming
//   capture_length[15:0]         words per capture (0 = 65536), latched
//   pipeO_read                   pop request
//   pipeO_data[31:0]             popped word (registered)
//   pipeO_ready                  fifo_count >= BLOCK_SIZE
//   capture_busy, capture_done   ARMED/CAPTURE, DONE
//   fifo_overflow                sticky; cleared by arming
//   fifo_underflow               sticky; cleared only by reset
//   fifo_count                   words buffered
// ----------------------------------------------------------------------------
module vector_capture_32in
  import vector_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned BLOCK_SIZE = BLOCK_SIZE_DEF
) (
  input  logic                         vectorclk,
  input  logic                         vectorreset,
  input  logic [31:0]                  vectorinput,
  input  logic                         capture_arm,
  input  logic [31:0]                  trig_mask,
  input  logic [31:0]                  trig_value,
  input  logic [15:0]                  capture_length,
  input  logic                         pipeO_read,
  output logic [31:0]                  pipeO_data,
  output logic                         pipeO_ready,
  output logic                         capture_busy,
  output logic                         capture_done,
  output logic                         fifo_overflow,
  output logic                         fifo_underflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  cap_state_e       state_q, state_d;
  logic [31:0]      sync1_q, sin_q;
  logic [31:0]      mask_q, mask_d;
  logic [31:0]      value_q, value_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_en;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    count_s;

  vector_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (vectorclk),
    .rst     (vectorreset),
    .wr_en   (wr_en),
    .wr_data (sin_q),
    .rd_en   (pipeO_read),
    .rd_data (pipeO_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count_s)
  );

  assign fifo_count     = count_s;
  assign pipeO_ready    = (count_s >= CW'(BLOCK_SIZE));
  assign capture_busy   = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign capture_done   = (state_q == ST_DONE);
  assign fifo_overflow  = overflow_q;
  assign fifo_underflow = underflow_q;

  // Capture FSM, word counting and sticky-flag next state.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    value_d     = value_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q | (pipeO_read & fifo_empty);
    wr_en       = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (capture_arm) begin
          state_d    = ST_ARMED;
          mask_d     = trig_mask;
          value_d    = trig_value;
          len_d      = capture_words(capture_length);
          word_cnt_d = {LEN_W{1'b0}};
          overflow_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_ARMED: begin
        // The triggering sample itself is word 0.
        if (trig_match(sin_q, mask_q, value_q)) begin
          wr_en      = 1'b1;
          word_cnt_d = {{(LEN_W-1){1'b0}}, 1'b1};
          if (len_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        wr_en      = 1'b1;
        word_cnt_d = word_cnt_q + 17'd1;
        if (word_cnt_d == len_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A write into a full buffer is dropped unless a pop frees a slot;
    // the word counter still advances so capture duration stays fixed.
    if (wr_en && fifo_full && !pipeO_read) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_d;
    end
  end

  // Input synchronizer, FSM state and latched capture parameters.
  always_ff @(posedge vectorclk or posedge vectorreset) begin
    if (vectorreset) begin
      sync1_q     <= 32'd0;
      sin_q       <= 32'd0;
      state_q     <= ST_IDLE;
      mask_q      <= 32'd0;
      value_q     <= 32'd0;
      len_q       <= {LEN_W{1'b0}};
      word_cnt_q  <= {LEN_W{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sync1_q     <= vectorinput;
      sin_q       <= sync1_q;
      state_q     <= state_d;
      mask_q      <= mask_d;
      value_q     <= value_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_vector_capture_32in.sv
// ----------------------------------------------------------------------------
// tb_vector_capture_32in
// Self-checking bench. The input is a ramp: after clock edge e the bench
// drives vectorinput = e - base, so the word written to the FIFO at edge e is
// (e - 3 - base) (two synchronizer stages plus the write register). With an
// arm sampled at edge A and a zero mask, word k of the capture is A-2+k.
// Expected words go into a scoreboard queue and are popped on each read.
// ----------------------------------------------------------------------------
module tb_vector_capture_32in;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] vin = 32'd0;
  logic        capture_arm = 1'b0;
  logic [31:0] trig_mask = 32'd0;
  logic [31:0] trig_value = 32'd0;
  logic [15:0] capture_length = 16'd0;
  logic        pipeO_read = 1'b0;
  logic [31:0] pipeO_data;
  logic        pipeO_ready;
  logic        capture_busy;
  logic        capture_done;
  logic        fifo_overflow;
  logic        fifo_underflow;
  logic [10:0] fifo_count;

  int          cyc = 0;
  int          base = 0;
  bit          ramp_on = 1'b1;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  vector_capture_32in dut (
    .vectorclk      (clk),
    .vectorreset    (rst),
    .vectorinput    (vin),
    .capture_arm    (capture_arm),
    .trig_mask      (trig_mask),
    .trig_value     (trig_value),
    .capture_length (capture_length),
    .pipeO_read     (pipeO_read),
    .pipeO_data     (pipeO_data),
    .pipeO_ready    (pipeO_ready),
    .capture_busy   (capture_busy),
    .capture_done   (capture_done),
    .fifo_overflow  (fifo_overflow),
    .fifo_underflow (fifo_underflow),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (ramp_on) vin = 32'(cyc - base);
  endtask

  // Arm with settled ramp; returns the cycle index of the arming edge.
  task automatic arm(input logic [31:0] m, input logic [31:0] v,
                     input logic [15:0] len, output int a);
    repeat (4) tick();
    trig_mask      = m;
    trig_value     = v;
    capture_length = len;
    capture_arm    = 1'b1;
    tick();
    capture_arm    = 1'b0;
    a = cyc;
  endtask

  task automatic pop(input string tag);
    logic [31:0] e;
    pipeO_read = 1'b1;
    tick();
    pipeO_read = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check_val(tag, pipeO_data, e);
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!capture_done && n < max) begin
      tick();
      n++;
    end
    check_val("done_seen", {31'd0, capture_done}, 32'd1);
  endtask

  initial begin
    int  a;
    int  n;
    bit  seen;

    // Reset values while reset is held.
    #1;
    check_val("rst_data",   pipeO_data, 32'd0);
    check_val("rst_count",  {21'd0, fifo_count}, 32'd0);
    check_val("rst_flags",  {26'd0, pipeO_ready, capture_busy, capture_done,
                             fifo_overflow, fifo_underflow, 1'b0}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Read from empty FIFO.
    pipeO_read = 1'b1;
    tick();
    pipeO_read = 1'b0;
    check_val("uf_data", pipeO_data, 32'd0);
    check_val("uf_flag", {31'd0, fifo_underflow}, 32'd1);
    check_val("uf_count", {21'd0, fifo_count}, 32'd0);

    // Mask 0xF / value 5 / length 4 on a ramp starting at 0.
    ramp_on = 1'b0;
    vin = 32'd0;
    repeat (3) tick();
    trig_mask = 32'h0000_000F;
    trig_value = 32'h0000_0005;
    capture_length = 16'd4;
    capture_arm = 1'b1;
    tick();
    capture_arm = 1'b0;
    check_val("t1_busy", {31'd0, capture_busy}, 32'd1);
    check_val("t1_uf_kept", {31'd0, fifo_underflow}, 32'd1);
    repeat (3) tick();
    check_val("t1_armed_cnt", {21'd0, fifo_count}, 32'd0);
    base = cyc;
    ramp_on = 1'b1;
    vin = 32'd0;
    for (int k = 5; k <= 8; k++) exp_q.push_back(32'(k));
    wait_done(100, n);
    check_val("t1_count", {21'd0, fifo_count}, 32'd4);
    for (int k = 0; k < 4; k++) pop("t1_word");
    check_val("t1_done", {31'd0, capture_done}, 32'd1);
    check_val("t1_count_end", {21'd0, fifo_count}, 32'd0);
    base = 0;

    // 300-word capture: pipeO_ready threshold both ways.
    arm(32'd0, 32'd0, 16'd300, a);
    for (int k = 0; k < 300; k++) exp_q.push_back(32'(a - 2 + k));
    seen = 1'b0;
    n = 0;
    while (!capture_done && n < 400) begin
      tick();
      n++;
      if (pipeO_ready && !seen) begin
        seen = 1'b1;
        check_val("t2_rise_count", {21'd0, fifo_count}, 32'd256);
      end
    end
    check_val("t2_done", {31'd0, capture_done}, 32'd1);
    check_val("t2_seen", {31'd0, seen}, 32'd1);
    check_val("t2_count", {21'd0, fifo_count}, 32'd300);
    for (int i = 1; i <= 45; i++) begin
      pop("t2_word");
      if (i == 44) begin
        check_val("t2_ready_44", {31'd0, pipeO_ready}, 32'd1);
        check_val("t2_count_44", {21'd0, fifo_count}, 32'd256);
      end
    end
    check_val("t2_ready_45", {31'd0, pipeO_ready}, 32'd0);
    check_val("t2_count_45", {21'd0, fifo_count}, 32'd255);
    for (int i = 0; i < 255; i++) pop("t2_drain");
    check_val("t2_empty", {21'd0, fifo_count}, 32'd0);

    // Length 0, mask 0, no reads: saturation, overflow, 65536-cycle duration.
    arm(32'd0, 32'd0, 16'd0, a);
    for (int k = 0; k < 1024; k++) exp_q.push_back(32'(a - 2 + k));
    wait_done(70000, n);
    check_val("t3_cycles", 32'(n), 32'd65536);
    check_val("t3_count", {21'd0, fifo_count}, 32'd1024);
    check_val("t3_ovf", {31'd0, fifo_overflow}, 32'd1);
    check_val("t3_busy", {31'd0, capture_busy}, 32'd0);
    for (int i = 0; i < 1024; i++) pop("t3_word");
    check_val("t3_empty", {21'd0, fifo_count}, 32'd0);

    // Full FIFO with one read and one write in the same cycle.
    arm(32'd0, 32'd0, 16'd1025, a);
    check_val("t4_ovf_clr", {31'd0, fifo_overflow}, 32'd0);
    for (int k = 0; k <= 1024; k++) exp_q.push_back(32'(a - 2 + k));
    n = 0;
    while (fifo_count != 11'd1024 && n < 1100) begin
      tick();
      n++;
    end
    check_val("t4_full", {21'd0, fifo_count}, 32'd1024);
    check_val("t4_busy", {31'd0, capture_busy}, 32'd1);
    pop("t4_rw_word");
    check_val("t4_count", {21'd0, fifo_count}, 32'd1024);
    check_val("t4_ovf", {31'd0, fifo_overflow}, 32'd0);
    check_val("t4_done", {31'd0, capture_done}, 32'd1);
    for (int i = 0; i < 1024; i++) pop("t4_word");
    check_val("t4_empty", {21'd0, fifo_count}, 32'd0);

    // Reset mid-capture at about word 10, then a normal capture.
    arm(32'd0, 32'd0, 16'd100, a);
    repeat (10) tick();
    check_val("t5_pre_count", {21'd0, fifo_count}, 32'd10);
    rst = 1'b1;
    #1;
    check_val("t5_rst_count", {21'd0, fifo_count}, 32'd0);
    check_val("t5_rst_data", pipeO_data, 32'd0);
    check_val("t5_rst_flags", {26'd0, pipeO_ready, capture_busy, capture_done,
                               fifo_overflow, fifo_underflow, 1'b0}, 32'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    arm(32'd0, 32'd0, 16'd3, a);
    for (int k = 0; k < 3; k++) exp_q.push_back(32'(a - 2 + k));
    wait_done(50, n);
    check_val("t5_count", {21'd0, fifo_count}, 32'd3);
    for (int i = 0; i < 3; i++) pop("t5_word");
    check_val("t5_empty", {21'd0, fifo_count}, 32'd0);
    check_val("t5_uf", {31'd0, fifo_underflow}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
